handshake_constant_arbiter: RTL and testbench
=============================================

# handshake_constant_arbiter

Shares one registered constant-output channel between `NUM_REQ` elastic control requesters. Each requester owns a fixed constant from a parameter table. On grant, the arbiter latches that constant and the requester index into a single-slot output buffer and presents them on one valid/ready output channel. It sits between several control-token producers and a shared consumer that would otherwise need one constant-generator instance per producer.

## Interface
Parameters:
- `NUM_REQ`, 4 — number of requesters; legal range 2..16.
- `DATA_WIDTH`, 32 — constant width.
- `CONSTS`, `{32'd4, 32'd3, 32'd2, 32'd1}` — flattened table of `NUM_REQ*DATA_WIDTH` bits; entry i = `CONSTS[i*DATA_WIDTH +: DATA_WIDTH]`; default entry i = i+1.
- `IDX_W` (localparam) = `$clog2(NUM_REQ)`.

Ports:
- `clk` input 1 — single clock, rising edge.
- `rst` input 1 — synchronous, active-low reset.
- `ctrl_valid` input `NUM_REQ` — per-requester token valid.
- `ctrl_ready` output `NUM_REQ` — per-requester accept; at most one bit high per cycle.
- `outs` output `DATA_WIDTH` — latched constant of the granted requester.
- `outs_idx` output `IDX_W` — index of the granted requester.
- `outs_valid` output 1 — output slot full.
- `outs_ready` input 1 — consumer accept.

## Operation
- Single output slot with registers `outs`, `outs_idx`, `outs_valid`.
- `can_load` = `!outs_valid || outs_ready`. Pass-through of `outs_ready` into the grant path is combinational.
- Arbitration is combinational over `ctrl_valid`.
  - Round-robin mode: search starts at pointer `ptr`.
  - Winner w = first valid index at or after `ptr`, wrapping modulo `NUM_REQ`.
- Grant signalling:
  - `ctrl_ready[w]` = `can_load`; all other `ctrl_ready` bits = 0.
  - With no valid requester, all `ctrl_ready` = 0.
- Accept: `ctrl_valid[w] && ctrl_ready[w]`. At the next edge:
  - `outs` <= entry w, `outs_idx` <= w, `outs_valid` <= 1.
  - `ptr` <= (w+1) mod `NUM_REQ`.
  - `ptr` wraps from `NUM_REQ-1` to 0.
- Drain without accept (`outs_valid && outs_ready`, no winner): `outs_valid` <= 0. `outs` and `outs_idx` hold their last values.
- Simultaneous drain and accept: the slot is overwritten with the new grant and `outs_valid` stays 1. No bubble.
- Output stability: while `outs_valid && !outs_ready`, `outs`, `outs_idx` and `outs_valid` are stable, and `ptr` does not change.
- `ptr` changes only on accept. A requester that drops valid loses nothing.
- `ctrl_ready` may depend on `ctrl_valid`. `outs_valid` never depends on `outs_ready` combinationally.

## Timing
- Reset (`rst`=0 at an edge):
  - `outs_valid`=0, `outs`=0, `outs_idx`=0, `ptr`=0.
  - All `ctrl_ready` forced 0 while `rst`=0.
- Latency: accept at edge N → `outs_valid`=1 and data visible after edge N.
- Throughput: 1 token/cycle while `outs_ready`=1.
- Reset mid-operation: a full slot is discarded. `outs_valid` is 0 after the reset edge regardless of `outs_ready`.
- Fairness: with all requesters continuously valid and no backpressure, each is granted exactly once every `NUM_REQ` cycles.

## Configuration
- Macro `HANDSHAKE_CONST_ARB_RR_EN`.
- Defined: round-robin arbitration with the `ptr` register as described above.
- Undefined: fixed priority, lowest index wins.
  - `ptr` is not implemented (behaves as constant 0).
  - Starvation of higher indices is permitted.
- Slot, handshake and reset behaviour are identical in both builds.

## Test plan
1. Reset: `rst`=0 for 3 cycles, all `ctrl_valid`=1, `outs_ready`=1 → `ctrl_ready`=0000 throughout; after reset `outs_valid`=0, `outs`=0.
2. Single requester: `ctrl_valid`=0100, `outs_ready`=1 → `ctrl_ready`=0100; next cycle `outs`=3, `outs_idx`=2, `outs_valid`=1; with valid removed, `outs_valid`=0 the cycle after.
3. Round-robin (RR_EN): `ctrl_valid`=1111, `outs_ready`=1 for 6 cycles → `outs_idx` sequence 0,1,2,3,0,1 and `outs` 1,2,3,4,1,2, with no bubbles.
4. Backpressure: slot holds idx 1, `outs_ready`=0 for 5 cycles with `ctrl_valid`=1111 → `ctrl_ready`=0000 and `outs`=2/`outs_idx`=1 stable. Then `outs_ready`=1 → the same cycle grants idx 2 and the next cycle shows `outs`=3.
5. Fixed priority (RR_EN undefined): `ctrl_valid`=1010 for 4 cycles, `outs_ready`=1 → every grant is idx 1 and idx 3 never gets `ctrl_ready`.
6. Reset mid-op: slot full (`outs_idx`=3), `ptr`=0 after wrap, `outs_ready`=0, `rst`=0 for one edge → `outs_valid`=0. Then with `ctrl_valid`=1111 the first grant is idx 0.

Source files
------------

// File: rtl/handshake_constant_arbiter_if.sv
// rtl/handshake_constant_arbiter_if.sv - requester tokens in, one constant/index channel out.
interface handshake_constant_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    ctrl_valid;
    logic [NUM_REQ-1:0]    ctrl_ready;
    logic [DATA_WIDTH-1:0] outs;
    logic [IDX_W-1:0]      outs_idx;
    logic                  outs_valid;
    logic                  outs_ready;

    modport master (
        input  ctrl_valid,
        input  outs_ready,
        output ctrl_ready,
        output outs,
        output outs_idx,
        output outs_valid
    );

    modport slave (
        output ctrl_valid,
        output outs_ready,
        input  ctrl_ready,
        input  outs,
        input  outs_idx,
        input  outs_valid
    );
endinterface

// File: rtl/handshake_constant_arbiter.sv
// rtl/handshake_constant_arbiter.sv - shares one registered constant slot between NUM_REQ requesters.
// HANDSHAKE_CONST_ARB_RR_EN selects round-robin; otherwise fixed priority, lowest index wins.
module handshake_constant_arbiter #(
    parameter int                            NUM_REQ    = 4,
    parameter int                            DATA_WIDTH = 32,
    parameter logic [NUM_REQ*DATA_WIDTH-1:0] CONSTS     = {32'd4, 32'd3, 32'd2, 32'd1}
) (
    input  logic                          clk,
    input  logic                          rst,
    handshake_constant_arbiter_if.master  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [DATA_WIDTH-1:0] outs_q, outs_d;
    logic [IDX_W-1:0]      outs_idx_q, outs_idx_d;
    logic                  outs_valid_q, outs_valid_d;
    logic [IDX_W-1:0]      win_idx;
    logic [IDX_W-1:0]      cand;
    logic                  win_found;
    logic                  can_load;
    logic                  accept;
`ifdef HANDSHAKE_CONST_ARB_RR_EN
    logic [IDX_W-1:0]      ptr_q, ptr_d;
`endif

    // Search order starts at ptr in round-robin mode, at 0 otherwise.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef HANDSHAKE_CONST_ARB_RR_EN
            cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
`else
            cand = IDX_W'(k);
`endif
            if (!win_found && bus.ctrl_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign can_load = !outs_valid_q || bus.outs_ready;
    assign accept   = rst && win_found && can_load;

    always_comb begin
        bus.ctrl_ready = '0;
        if (accept) begin
            bus.ctrl_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        outs_d       = outs_q;
        outs_idx_d   = outs_idx_q;
        outs_valid_d = outs_valid_q;
`ifdef HANDSHAKE_CONST_ARB_RR_EN
        ptr_d        = ptr_q;
`endif
        if (accept) begin
            // A drain in the same cycle is simply overwritten, so no bubble appears.
            outs_d       = CONSTS[win_idx*DATA_WIDTH +: DATA_WIDTH];
            outs_idx_d   = win_idx;
            outs_valid_d = 1'b1;
`ifdef HANDSHAKE_CONST_ARB_RR_EN
            ptr_d        = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
        end else if (bus.outs_ready) begin
            outs_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            outs_q       <= '0;
            outs_idx_q   <= '0;
            outs_valid_q <= 1'b0;
`ifdef HANDSHAKE_CONST_ARB_RR_EN
            ptr_q        <= '0;
`endif
        end else begin
            outs_q       <= outs_d;
            outs_idx_q   <= outs_idx_d;
            outs_valid_q <= outs_valid_d;
`ifdef HANDSHAKE_CONST_ARB_RR_EN
            ptr_q        <= ptr_d;
`endif
        end
    end

    assign bus.outs       = outs_q;
    assign bus.outs_idx   = outs_idx_q;
    assign bus.outs_valid = outs_valid_q;
endmodule

// File: tb/tb_handshake_constant_arbiter.sv
// tb/tb_handshake_constant_arbiter.sv - directed and random checks against a behavioural slot model.
module tb_handshake_constant_arbiter;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    handshake_constant_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(32)) bus ();

    handshake_constant_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: one slot plus the search start; constant of requester i is i+1.
    int   m_ptr;
    logic m_valid;
    int   m_data;
    int   m_idx;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int m_winner(input logic [3:0] v);
        for (int k = 0; k < 4; k++) begin
            if (v[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        end
        return -1;
    endfunction

    task automatic step(input logic [3:0] v, input logic r, input logic rn, input string tag);
        int         w;
        logic [3:0] exp_rdy;
        bus.ctrl_valid = v;
        bus.outs_ready = r;
        rst            = rn;
        #1;
        w       = m_winner(v);
        exp_rdy = (rn && w >= 0 && (!m_valid || r)) ? (4'b0001 << w) : 4'b0000;
        chk({tag, ":ctrl_ready"}, 32'(bus.ctrl_ready), 32'(exp_rdy));
        @(posedge clk);
        if (!rn) begin
            m_valid = 1'b0; m_data = 0; m_idx = 0; m_ptr = 0;
        end else if (exp_rdy != 4'b0000) begin
            m_valid = 1'b1; m_data = w + 1; m_idx = w;
`ifdef HANDSHAKE_CONST_ARB_RR_EN
            m_ptr = (w + 1) % 4;
`endif
        end else if (r) begin
            m_valid = 1'b0;
        end
        #1;
        chk({tag, ":outs_valid"}, 32'(bus.outs_valid), 32'(m_valid));
        chk({tag, ":outs"}, bus.outs, 32'(m_data));
        chk({tag, ":outs_idx"}, 32'(bus.outs_idx), 32'(m_idx));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        m_ptr   = 0;
        m_valid = 1'b0;
        m_data  = 0;
        m_idx   = 0;
        rst            = 1'b0;
        bus.ctrl_valid = 4'b1111;
        bus.outs_ready = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 1'b0, "reset");

        step(4'b0100, 1'b1, 1'b1, "single");
        chk("single:const", bus.outs, 32'd3);
        step(4'b0000, 1'b1, 1'b1, "single_drain");

        step(4'b0000, 1'b1, 1'b0, "rr_reset");
        for (int i = 0; i < 6; i++) begin
            step(4'b1111, 1'b1, 1'b1, "rr");
`ifdef HANDSHAKE_CONST_ARB_RR_EN
            chk("rr:seq", 32'(bus.outs_idx), 32'(i % 4));
`else
            chk("fp:seq", 32'(bus.outs_idx), 32'd0);
`endif
        end

        for (int i = 0; i < 5; i++) step(4'b1111, 1'b0, 1'b1, "backpressure");
        step(4'b1111, 1'b1, 1'b1, "release");
        step(4'b0000, 1'b1, 1'b1, "release_drain");

        for (int i = 0; i < 4; i++) step(4'b1010, 1'b1, 1'b1, "prio");

        for (int i = 0; i < 4; i++) step(4'b1111, 1'b1, 1'b1, "wrap");
        step(4'b1000, 1'b1, 1'b1, "fill3");
        step(4'b1111, 1'b0, 1'b0, "mid_reset");
        step(4'b1111, 1'b1, 1'b1, "post_reset");
        chk("post_reset:idx", 32'(bus.outs_idx), 32'd0);

        for (int i = 0; i < 400; i++) begin
            step(4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) != 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
